// File: rtl/dec_output_ctrl_pipe.sv
// Registered decoder output stage: single-error correction, error classification,
// valid/ready output register and saturating corrected/uncorrectable counters.
module dec_output_ctrl_pipe #(
    parameter  int CW_WIDTH  = 32,
    parameter  int CNT_WIDTH = 16,
    localparam int COL_W     = $clog2(CW_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW_WIDTH-1:0]  codeword,
    input  logic                 areThereErrors,
    input  logic                 isThereOneError,
    input  logic [COL_W-1:0]     whichColIsError,
    input  logic                 correct_en,
    input  logic                 clr_stats,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW_WIDTH-1:0]  data_out,
    output logic [1:0]           num_of_errors,
    output logic [CNT_WIDTH-1:0] corr_cnt,
    output logic [CNT_WIDTH-1:0] uncorr_cnt
);

    localparam logic [31:0]    CW_LIMIT = 32'(CW_WIDTH);
    localparam logic [1:0]     CLS_NONE = 2'b00;
    localparam logic [1:0]     CLS_ONE  = 2'b01;
    localparam logic [1:0]     CLS_MULT = 2'b10;

    logic                 valid_q,  valid_d;
    logic [CW_WIDTH-1:0]  data_q,   data_d;
    logic [1:0]           class_q,  class_d;
    logic [CNT_WIDTH-1:0] corr_q,   corr_d;
    logic [CNT_WIDTH-1:0] uncorr_q, uncorr_d;

    logic                 accept;
    logic                 xfer;
    logic                 col_in_range;
    logic                 single_ok;
    logic [1:0]           class_in;
    logic [CW_WIDTH-1:0]  flip_mask;

    assign in_ready      = !valid_q || out_ready;
    assign accept        = in_valid && in_ready;
    assign xfer          = valid_q && out_ready;

    assign out_valid     = valid_q;
    assign data_out      = data_q;
    assign num_of_errors = class_q;
    assign corr_cnt      = corr_q;
    assign uncorr_cnt    = uncorr_q;

    // Columns beyond the data width can occur for non-power-of-two widths; treat as uncorrectable.
    assign col_in_range  = {{(32-COL_W){1'b0}}, whichColIsError} < CW_LIMIT;
    assign single_ok     = isThereOneError && col_in_range;

    always_comb begin
        class_in = CLS_NONE;
        if (single_ok) begin
            class_in = CLS_ONE;
        end else if (isThereOneError || areThereErrors) begin
            class_in = CLS_MULT;
        end
    end

    // Mask is forced to zero unless a valid single error is corrected, so an
    // undriven column index cannot leak into the data path.
    always_comb begin
        flip_mask = '0;
        if (single_ok && correct_en) begin
            flip_mask = {{(CW_WIDTH-1){1'b0}}, 1'b1} << whichColIsError;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        class_d  = class_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;

        if (accept) begin
            valid_d = 1'b1;
            data_d  = codeword ^ flip_mask;
            class_d = class_in;
        end else if (xfer) begin
            valid_d = 1'b0;
        end

        if (clr_stats) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else if (accept) begin
            if (class_in == CLS_ONE && corr_q != {CNT_WIDTH{1'b1}}) begin
                corr_d = corr_q + 1'b1;
            end
            if (class_in == CLS_MULT && uncorr_q != {CNT_WIDTH{1'b1}}) begin
                uncorr_d = uncorr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            class_q  <= CLS_NONE;
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            class_q  <= class_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
        end
    end

endmodule

// File: tb/tb_dec_output_ctrl_pipe.sv
// Directed bench for dec_output_ctrl_pipe: a 32-bit/16-bit-counter instance and a
// 24-bit/2-bit-counter instance for out-of-range columns and counter saturation.
module tb_dec_output_ctrl_pipe;

    logic clk;
    logic rst;

    // Main instance (CW_WIDTH=32, CNT_WIDTH=16)
    logic        in_valid, in_ready, are_err, one_err, cen, clr, out_valid, out_ready;
    logic [31:0] cw, dout;
    logic [4:0]  col;
    logic [1:0]  nerr;
    logic [15:0] ccnt, ucnt;

    // Small instance (CW_WIDTH=24, CNT_WIDTH=2)
    logic        s_in_valid, s_in_ready, s_are_err, s_one_err, s_cen, s_clr, s_out_valid, s_out_ready;
    logic [23:0] s_cw, s_dout;
    logic [4:0]  s_col;
    logic [1:0]  s_nerr;
    logic [1:0]  s_ccnt, s_ucnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] rx_q[$];

    dec_output_ctrl_pipe #(.CW_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .codeword(cw),
        .areThereErrors(are_err), .isThereOneError(one_err), .whichColIsError(col),
        .correct_en(cen), .clr_stats(clr), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(dout), .num_of_errors(nerr), .corr_cnt(ccnt), .uncorr_cnt(ucnt)
    );

    dec_output_ctrl_pipe #(.CW_WIDTH(24), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .codeword(s_cw),
        .areThereErrors(s_are_err), .isThereOneError(s_one_err), .whichColIsError(s_col),
        .correct_en(s_cen), .clr_stats(s_clr), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .data_out(s_dout), .num_of_errors(s_nerr), .corr_cnt(s_ccnt), .uncorr_cnt(s_ucnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word the consumer actually takes.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) rx_q.push_back(dout);
    end

    typedef struct {
        logic [31:0] cw;
        logic        any;
        logic        one;
        logic [4:0]  col;
        logic        cen;
        logic [31:0] exp_data;
        logic [1:0]  exp_cls;
        logic [15:0] exp_corr;
        logic [15:0] exp_uncorr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic s_single(input logic [4:0] c, input logic clr_i,
                            input logic [23:0] exp_d, input logic [1:0] exp_cc);
        s_in_valid = 1'b1; s_cw = 24'h0; s_are_err = 1'b1; s_one_err = 1'b1;
        s_col = c; s_cen = 1'b1; s_clr = clr_i;
        @(posedge clk); #1;
        check("sat_data", 64'(s_dout), 64'(exp_d));
        check("sat_cls", 64'(s_nerr), 64'(2'b01));
        check("sat_corr", 64'(s_ccnt), 64'(exp_cc));
    endtask

    initial begin
        vecs[0] = '{32'h0000008B, 1'b0, 1'b0, 5'd0,  1'b1, 32'h0000008B, 2'b00, 16'd0, 16'd0};
        vecs[1] = '{32'h000000AA, 1'b0, 1'b1, 5'd5,  1'b1, 32'h0000008A, 2'b01, 16'd1, 16'd0};
        vecs[2] = '{32'h000000AA, 1'b0, 1'b1, 5'd5,  1'b0, 32'h000000AA, 2'b01, 16'd2, 16'd0};
        vecs[3] = '{32'hAAAAAAAA, 1'b1, 1'b0, 5'd3,  1'b1, 32'hAAAAAAAA, 2'b10, 16'd2, 16'd1};
        vecs[4] = '{32'hFFFFFFFF, 1'b1, 1'b1, 5'd31, 1'b1, 32'h7FFFFFFF, 2'b01, 16'd3, 16'd1};
        vecs[5] = '{32'h00000000, 1'b1, 1'b1, 5'd0,  1'b1, 32'h00000001, 2'b01, 16'd4, 16'd1};
        vecs[6] = '{32'h12345678, 1'b1, 1'b0, 5'd0,  1'b1, 32'h12345678, 2'b10, 16'd4, 16'd2};

        rst = 1'b1;
        in_valid = 1'b0; cw = '0; are_err = 1'b0; one_err = 1'b0; col = '0;
        cen = 1'b1; clr = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_cw = '0; s_are_err = 1'b0; s_one_err = 1'b0; s_col = '0;
        s_cen = 1'b1; s_clr = 1'b0; s_out_ready = 1'b1;

        #12;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", 64'(dout), 64'(0));
        check("rst_cls", 64'(nerr), 64'(0));
        check("rst_corr", 64'(ccnt), 64'(0));
        check("rst_uncorr", 64'(ucnt), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Table vectors, streamed back to back with out_ready held high.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; cw = vecs[i].cw; are_err = vecs[i].any;
            one_err = vecs[i].one; col = vecs[i].col; cen = vecs[i].cen;
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
            check($sformatf("vec%0d_data", i), 64'(dout), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_cls", i), 64'(nerr), 64'(vecs[i].exp_cls));
            check($sformatf("vec%0d_corr", i), 64'(ccnt), 64'(vecs[i].exp_corr));
            check($sformatf("vec%0d_uncorr", i), 64'(ucnt), 64'(vecs[i].exp_uncorr));
        end

        // Undriven column index on an uncorrectable word must not disturb the data.
        cw = 32'hAAAAAAAA; are_err = 1'b1; one_err = 1'b0; col = 'z; cen = 1'b1;
        @(posedge clk); #1;
        check("zcol_data", 64'(dout), 64'(32'hAAAAAAAA));
        check("zcol_cls", 64'(nerr), 64'(2'b10));
        check("zcol_uncorr", 64'(ucnt), 64'(3));
        in_valid = 1'b0; col = '0; are_err = 1'b0;
        @(posedge clk); #1;
        check("drain_valid", 64'(out_valid), 64'(0));

        // Backpressure: three words, four stall cycles after the first.
        rx_q.delete();
        in_valid = 1'b1; cw = 32'h11111111; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; cw = 32'h22222222;
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_data", k), 64'(dout), 64'(32'h11111111));
            check($sformatf("bp_hold%0d_valid", k), 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_second", 64'(dout), 64'(32'h22222222));
        cw = 32'h33333333;
        @(posedge clk); #1;
        check("bp_third", 64'(dout), 64'(32'h33333333));
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_drained", 64'(out_valid), 64'(0));
        check("bp_count", 64'(rx_q.size()), 64'(3));
        if (rx_q.size() == 3) begin
            check("bp_order0", 64'(rx_q[0]), 64'(32'h11111111));
            check("bp_order1", 64'(rx_q[1]), 64'(32'h22222222));
            check("bp_order2", 64'(rx_q[2]), 64'(32'h33333333));
        end
        check("bp_corr_unchanged", 64'(ccnt), 64'(4));

        // Reset while a word is stalled at the output.
        in_valid = 1'b1; cw = 32'h55555555; are_err = 1'b1; one_err = 1'b1; col = 5'd1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_data", 64'(dout), 64'(32'h55555557));
        #2 rst = 1'b1;
        #1;
        check("mrst_valid", 64'(out_valid), 64'(0));
        check("mrst_data", 64'(dout), 64'(0));
        check("mrst_cls", 64'(nerr), 64'(0));
        check("mrst_corr", 64'(ccnt), 64'(0));
        check("mrst_uncorr", 64'(ucnt), 64'(0));
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1; are_err = 1'b0; one_err = 1'b0;

        // 24-bit instance: column 30 is out of range and must classify as uncorrectable.
        s_in_valid = 1'b1; s_cw = 24'h000001; s_are_err = 1'b0; s_one_err = 1'b1; s_col = 5'd30;
        @(posedge clk); #1;
        check("oor_data", 64'(s_dout), 64'(24'h000001));
        check("oor_cls", 64'(s_nerr), 64'(2'b10));
        check("oor_uncorr", 64'(s_ucnt), 64'(1));
        check("oor_corr", 64'(s_ccnt), 64'(0));
        s_col = 5'd23;
        @(posedge clk); #1;
        check("edge23_data", 64'(s_dout), 64'(24'h800001));
        check("edge23_cls", 64'(s_nerr), 64'(2'b01));

        // 2-bit counter saturation, then clear racing an increment. edge23 already counted once.
        s_single(5'd0, 1'b0, 24'h000001, 2'd2);
        s_single(5'd1, 1'b0, 24'h000002, 2'd3);
        s_single(5'd2, 1'b0, 24'h000004, 2'd3);
        s_single(5'd3, 1'b0, 24'h000008, 2'd3);
        s_single(5'd4, 1'b0, 24'h000010, 2'd3);
        s_single(5'd5, 1'b1, 24'h000020, 2'd0);
        check("clr_uncorr", 64'(s_ucnt), 64'(0));
        s_in_valid = 1'b0; s_clr = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
